sincos2saw: RTL

//  Inverse of the phase-to-sine path: recovers a 16-bit sawtooth phase (full turn = 2^16)
//  and a raw magnitude from a sine/cosine pair. Uses an iterative vectoring-mode CORDIC,
//  one micro-rotation per clock, behind valid/ready handshakes.

---
 rtl/sincos2saw_if.sv | 17 +
 rtl/sincos2saw.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sincos2saw_if.sv
// Handshake bundle for the sine/cosine-to-phase converter.
// The sample channel flows into the block and the result channel flows out of it.
interface sincos2saw_if;
  logic [15:0] sin;
  logic [15:0] cos;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] saw;
  logic [16:0] mag;
  logic        result_valid;
  logic        result_ready;

  modport master (output sin, cos, sample_valid, result_ready,
                  input  sample_ready, saw, mag, result_valid);
  modport slave  (input  sin, cos, sample_valid, result_ready,
                  output sample_ready, saw, mag, result_valid);
endinterface

// File: rtl/sincos2saw.sv
// Recovers a 16-bit sawtooth phase and raw magnitude from an offset-binary sine/cosine pair.
// Uses an iterative vectoring CORDIC that performs one micro-rotation per clock.
module sincos2saw #(
  parameter int ITERS = 14
) (
  input logic         clk,
  input logic         rst,
  sincos2saw_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] LAST_IDX = 5'(ITERS - 1);

  state_t             state_r;
  logic signed [17:0] x_r;
  logic signed [17:0] y_r;
  logic [15:0]        z_r;
  logic [4:0]         i_r;
  logic               zflag_r;
  logic               ready_r;
  logic               valid_r;
  logic [15:0]        saw_r;
  logic [16:0]        mag_r;

  logic signed [17:0] xa_s;
  logic signed [17:0] ya_s;
  logic signed [17:0] x0_s;
  logic signed [17:0] y0_s;
  logic [15:0]        z0_s;
  logic               zero_s;
  logic signed [17:0] xs_s;
  logic signed [17:0] ys_s;
  logic signed [17:0] xn_s;
  logic signed [17:0] yn_s;
  logic [15:0]        zn_s;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] v;
    case (idx)
      4'd0:    v = 16'd8192;
      4'd1:    v = 16'd4836;
      4'd2:    v = 16'd2555;
      4'd3:    v = 16'd1297;
      4'd4:    v = 16'd651;
      4'd5:    v = 16'd326;
      4'd6:    v = 16'd163;
      4'd7:    v = 16'd81;
      4'd8:    v = 16'd41;
      4'd9:    v = 16'd20;
      4'd10:   v = 16'd10;
      4'd11:   v = 16'd5;
      4'd12:   v = 16'd3;
      4'd13:   v = 16'd1;
      4'd14:   v = 16'd1;
      4'd15:   v = 16'd0;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Offset-binary to signed conversion and half-plane fold so that x starts non-negative.
  always_comb begin
    xa_s   = {{2{~bus.cos[15]}}, ~bus.cos[15], bus.cos[14:0]};
    ya_s   = {{2{~bus.sin[15]}}, ~bus.sin[15], bus.sin[14:0]};
    zero_s = (xa_s == 18'sd0) && (ya_s == 18'sd0);
    if (xa_s[17]) begin
      // 18 bits so that negating -32768 stays in range
      x0_s = -xa_s;
      y0_s = -ya_s;
      z0_s = 16'h8000;
    end else begin
      x0_s = xa_s;
      y0_s = ya_s;
      z0_s = 16'h0000;
    end
  end

  // One vectoring micro-rotation driving y toward zero; z wraps modulo a full turn.
  always_comb begin
    xs_s = x_r >>> i_r;
    ys_s = y_r >>> i_r;
    if (!y_r[17]) begin
      xn_s = x_r + ys_s;
      yn_s = y_r - xs_s;
      zn_s = z_r + atan_lut(i_r[3:0]);
    end else begin
      xn_s = x_r - ys_s;
      yn_s = y_r + xs_s;
      zn_s = z_r - atan_lut(i_r[3:0]);
    end
  end

  // Control FSM with CORDIC datapath and registered result/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      x_r     <= 18'sd0;
      y_r     <= 18'sd0;
      z_r     <= 16'h0000;
      i_r     <= 5'd0;
      zflag_r <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      saw_r   <= 16'h0000;
      mag_r   <= 17'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.sample_valid && ready_r) begin
            x_r     <= x0_s;
            y_r     <= y0_s;
            z_r     <= z0_s;
            zflag_r <= zero_s;
            i_r     <= 5'd0;
            ready_r <= 1'b0;
            state_r <= ITER;
          end
        end
        ITER: begin
          x_r <= xn_s;
          y_r <= yn_s;
          z_r <= zn_s;
          i_r <= i_r + 5'd1;
          if (i_r == LAST_IDX) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the consumer.
          if (!valid_r) begin
            saw_r   <= zflag_r ? 16'h0000 : z_r;
            mag_r   <= zflag_r ? 17'd0 : x_r[16:0];
            valid_r <= 1'b1;
          end else if (bus.result_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_ready = ready_r;
  assign bus.result_valid = valid_r;
  assign bus.saw          = saw_r;
  assign bus.mag          = mag_r;
endmodule
